// File: rtl/inv_sub_bytes_iter_pkg.sv
// Shared AES definitions: byte/state types, FSM encoding and the forward and inverse S-box tables.
package inv_sub_bytes_iter_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned AES_N       = 4;
    localparam int unsigned STATE_BYTES = AES_N * AES_N;

    typedef logic [BYTE_W-1:0] aes_byte_t;
    // state[row][col]; flat byte index 4*row+col lines up with the packed layout
    typedef aes_byte_t [AES_N-1:0][AES_N-1:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } isb_fsm_e;

    localparam aes_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam aes_byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_sub_bytes_iter_if.sv
// Valid/ready state-in / result-out bus of the iterative InvSubBytes block.
interface inv_sub_bytes_iter_if;
    import inv_sub_bytes_iter_pkg::*;

    aes_state_t state;
    logic       in_valid;
    logic       in_ready;
    aes_state_t o;
    logic       out_valid;
    logic       out_ready;

    modport master (output state, in_valid, out_ready, input in_ready, o, out_valid);
    modport slave  (input state, in_valid, out_ready, output in_ready, o, out_valid);
endinterface

// File: rtl/inv_sub_bytes_iter_inv_sbox.sv
// Single-byte combinational AES inverse S-box lookup.
module inv_sbox
    import inv_sub_bytes_iter_pkg::*;
(
    input  aes_byte_t lhs,
    output aes_byte_t o
);
    assign o = INV_SBOX[lhs];
endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: latches a 16-byte state and substitutes LANES bytes
// per cycle in row-major order, then holds the result until the consumer takes it.
module inv_sub_bytes_iter
    import inv_sub_bytes_iter_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    inv_sub_bytes_iter_if.slave  bus
);
    localparam int unsigned      IDX_W    = 4;
    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STATE_BYTES - LANES);

    isb_fsm_e                     fsm_q, fsm_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    aes_byte_t [STATE_BYTES-1:0]  work_q, work_d;
    logic                         in_ready_q, in_ready_d;
    logic                         out_valid_q, out_valid_d;
    aes_byte_t [LANES-1:0]        lane_in, lane_out;

    // Lane l works on flat byte idx+l; the 4-bit sum never exceeds 15 inside a pass
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_in[l] = work_q[idx_q + IDX_W'(l)];
        inv_sbox u_inv_sbox (.lhs(lane_in[l]), .o(lane_out[l]));
    end

    always_comb begin
        fsm_d       = fsm_q;
        idx_d       = idx_q;
        work_d      = work_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (fsm_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d     = bus.state;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    fsm_d      = BUSY;
                end
            end
            BUSY: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    work_d[idx_q + IDX_W'(l)] = lane_out[l];
                end
                idx_d = idx_q + IDX_STEP;
                if (idx_q == IDX_LAST) begin
                    out_valid_d = 1'b1;
                    fsm_d       = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    fsm_d       = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                fsm_d       = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            idx_q       <= '0;
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            idx_q       <= idx_d;
            work_q      <= work_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.o         = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed bench for inv_sub_bytes_iter: LANES 1, 4 and 16 instances driven in lockstep.
module tb_inv_sub_bytes_iter;
    import inv_sub_bytes_iter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    aes_state_t st_drv;
    logic       in_valid_drv;
    logic       out_ready_drv;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    inv_sub_bytes_iter_if b1 ();
    inv_sub_bytes_iter_if b4 ();
    inv_sub_bytes_iter_if b16 ();

    assign b1.state      = st_drv;
    assign b1.in_valid   = in_valid_drv;
    assign b1.out_ready  = out_ready_drv;
    assign b4.state      = st_drv;
    assign b4.in_valid   = in_valid_drv;
    assign b4.out_ready  = out_ready_drv;
    assign b16.state     = st_drv;
    assign b16.in_valid  = in_valid_drv;
    assign b16.out_ready = out_ready_drv;

    inv_sub_bytes_iter #(.LANES(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    inv_sub_bytes_iter #(.LANES(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    inv_sub_bytes_iter #(.LANES(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {in_ready x3, out_valid x3} for dut1, dut4, dut16
    function automatic logic [5:0] flags();
        return {b1.in_ready, b4.in_ready, b16.in_ready, b1.out_valid, b4.out_valid, b16.out_valid};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_flags"}, 128'(flags()), 128'(6'b111_000));
    endtask

    task automatic check_zero_out(input string tag);
        check({tag, "_o1"},  b1.o,  '0);
        check({tag, "_o4"},  b4.o,  '0);
        check({tag, "_o16"}, b16.o, '0);
    endtask

    // One transaction through all three instances; latency measured per instance
    task automatic run_txn(input string tag, input aes_state_t st, input aes_state_t exp,
                           input bit disturb, input int hold);
        int lat1, lat4, lat16;
        bit stable;
        lat1 = 0; lat4 = 0; lat16 = 0; stable = 1'b1;
        st_drv       = st;
        in_valid_drv = 1'b1;
        @(posedge clk); #1;
        in_valid_drv = 1'b0;
        for (int c = 1; c <= 40 && (lat1 == 0 || lat4 == 0 || lat16 == 0); c++) begin
            if (disturb) begin
                in_valid_drv = c[0];
                st_drv       = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk); #1;
            if (lat1  == 0 && b1.out_valid)  lat1  = c;
            if (lat4  == 0 && b4.out_valid)  lat4  = c;
            if (lat16 == 0 && b16.out_valid) lat16 = c;
        end
        in_valid_drv = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (b4.o !== exp || b4.out_valid !== 1'b1 || b4.in_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) check({tag, "_hold_stable"}, 128'(stable), 128'(1'b1));
        check({tag, "_lat1"},  128'(lat1),  128'(16));
        check({tag, "_lat4"},  128'(lat4),  128'(4));
        check({tag, "_lat16"}, 128'(lat16), 128'(1));
        check({tag, "_o1"},  b1.o,  exp);
        check({tag, "_o4"},  b4.o,  exp);
        check({tag, "_o16"}, b16.o, exp);
        check({tag, "_done_flags"}, 128'(flags()), 128'(6'b000_111));
        out_ready_drv = 1'b1;
        @(posedge clk); #1;
        out_ready_drv = 1'b0;
        check_idle({tag, "_release"});
    endtask

    initial begin
        aes_state_t st, exp;

        rst_n         = 1'b1;
        in_valid_drv  = 1'b0;
        out_ready_drv = 1'b0;
        st_drv        = '0;
        #1 rst_n = 1'b0;
        #2;
        check_idle("reset");
        check_zero_out("reset");
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("post_reset");

        // All 0x63 decode to 0x00
        st  = {16{8'h63}};
        exp = '0;
        run_txn("all63", st, exp, 1'b0, 0);

        // Row 0 {00,7C,16,52}, rest 0x63
        st  = {16{8'h63}};
        st[0][0] = 8'h00; st[0][1] = 8'h7c; st[0][2] = 8'h16; st[0][3] = 8'h52;
        exp = '0;
        exp[0][0] = 8'h52; exp[0][1] = 8'h01; exp[0][2] = 8'hff; exp[0][3] = 8'h48;
        run_txn("row0", st, exp, 1'b0, 0);

        // Back-pressure: ten cycles of out_ready=0 in DONE
        run_txn("hold", st, exp, 1'b0, 10);

        // Reset during the second BUSY cycle discards the transaction
        st_drv       = {16{8'h11}};
        in_valid_drv = 1'b1;
        @(posedge clk); #1;
        in_valid_drv = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_idle("midreset");
        check_zero_out("midreset");
        #2 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_idle("midreset_after");
        st  = {16{8'h63}};
        st[3][3] = 8'h00;
        exp = '0;
        exp[3][3] = 8'h52;
        run_txn("after_reset", st, exp, 1'b0, 0);

        // In-flight in_valid toggling and state changes must be ignored
        st  = {16{8'h63}};
        st[1][2] = 8'h7c; st[2][1] = 8'h16;
        exp = '0;
        exp[1][2] = 8'h01; exp[2][1] = 8'hff;
        run_txn("disturb", st, exp, 1'b1, 0);

        // Round trip of every byte value through the forward S-box
        for (int t = 0; t < 16; t++) begin
            for (int b = 0; b < 16; b++) begin
                st[b / 4][b % 4]  = SBOX[16 * t + b];
                exp[b / 4][b % 4] = 8'(16 * t + b);
            end
            run_txn($sformatf("sweep%0d", t), st, exp, 1'b0, 0);
        end

        // Random round trips
        for (int t = 0; t < 6; t++) begin
            for (int b = 0; b < 16; b++) begin
                exp[b / 4][b % 4] = 8'($urandom);
                st[b / 4][b % 4]  = SBOX[exp[b / 4][b % 4]];
            end
            run_txn($sformatf("rand%0d", t), st, exp, 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_iter.md
INV_SUB_BYTES_ITER -- requirements
Module: inv_sub_bytes_iter

Interface
REQ-001 Parameter LANES, default 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-low.
REQ-004 state  in  8 x [4][4]  ciphertext-side AES state, indexed [row][col].
REQ-005 in_valid  in  1  state is valid this cycle.
REQ-006 in_ready  out  1  block can accept a state this cycle.
REQ-007 o  out  8 x [4][4]  InvSubBytes(state); o[r][c] = InvSbox(state[r][c]).
REQ-008 out_valid  out  1  o holds a completed result.
REQ-009 out_ready  in  1  consumer accepts o this cycle.

Function
REQ-010 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-011 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-012 IDLE: when in_valid=1, the block SHALL latch state into an internal 16-byte working register, clear the byte index to 0 and go to BUSY.
REQ-013 Byte order SHALL be row-major: flat index i = 4*row + col.
REQ-014 BUSY, each cycle: bytes i..i+LANES-1 SHALL be replaced by their InvSbox values and the index SHALL advance by LANES.
REQ-015 The BUSY cycle that processes index 16-LANES SHALL transition to DONE.
REQ-016 The index counter SHALL be 4 bits wide; the wrap to 0 SHALL be ignored.
REQ-017 Latency: with acceptance at edge k, out_valid SHALL rise after edge k+16/LANES (LANES=4: 4 cycles).
REQ-018 DONE: o SHALL equal the working register and SHALL remain stable while out_ready=0.
REQ-019 DONE with out_ready=1 SHALL transition to IDLE on that edge.
REQ-020 The earliest next acceptance SHALL be the cycle after that transition; input and output transactions never overlap.
REQ-021 in_valid SHALL be ignored outside IDLE, and state changes after acceptance SHALL have no effect on the result.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 InvSbox SHALL be the FIPS-197 inverse S-box, bit-exact; for all x, InvSbox(Sbox(x)) = x.

Reset
REQ-024 On rst=0, regardless of state or mid-BUSY progress, the block SHALL immediately:
- enter IDLE;
- clear the index to 0;
- clear the working register to all 0x00.
REQ-025 Output values during reset SHALL be: in_ready=1, out_valid=0, o all 0x00.
REQ-026 A transaction interrupted by reset SHALL be discarded; no partial result is ever flagged valid.

Structure
REQ-027 The following SHALL live in the shared AES defs package, alongside the forward S-box constant:
- the byte type;
- the 4x4 AES state type;
- the 256-entry inverse S-box constant.
REQ-028 One sub-module, inv_sbox (8-bit combinational lookup lhs -> o), SHALL be instantiated LANES times.
REQ-029 The lane inputs SHALL be muxed from the working register by the index.

Verification
REQ-030 Reset, then state all 0x63 with in_valid pulsed one cycle (LANES=4) -> out_valid high after exactly 4 cycles, o all 0x00.
REQ-031 state rows {00,7C,16,52 | ...} (row 0 as shown, remaining bytes 0x63) -> row 0 of o = {52,01,FF,48}, remaining bytes 0x00.
REQ-032 Hold out_ready=0 for 10 cycles in DONE -> o and out_valid stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-033 Assert rst=0 on the second BUSY cycle -> out_valid=0, in_ready=1 and o all 0x00 immediately; the subsequent transaction completes correctly.
REQ-034 Random states through the forward subBytes, then this block, for LANES in {1,4,16} -> output equals original; latency 16, 4 and 1 cycles respectively.
REQ-035 Toggle in_valid and change state during BUSY -> no effect on the result or the FSM.
